theta_slice_sequencer: RTL and testbench

- FSM controller for the 64-slice parity datapath (1600-bit state = 64 slices x 25 bits).
- On a start request it clears the 64 slice registers, then steps the slice select 0..63, enabling one register write per slice.
- Signals completion to the round-level control, and supports a stall that freezes the sweep.
- Sits between the round controller and the datapath; it drives the datapath's cntSelOut, regRst and regWrite.

---
 rtl/theta_slice_sequencer_pkg.sv | 18 +
 rtl/theta_slice_sequencer_slice_counter.sv | 41 ++++
 rtl/theta_slice_sequencer.sv | 75 +++++++
 tb/tb_theta_slice_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/theta_slice_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | theta_slice_sequencer_pkg                                         |
// | Shared slice geometry and sequencer state encoding.               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package theta_slice_sequencer_pkg;

  localparam int c_CNT_W      = 6;
  localparam int c_NUM_SLICES = 64;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_CLEAR = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/theta_slice_sequencer_slice_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | theta_slice_sequencer_slice_counter                               |
// | Slice-select up-counter with sync clear, enable and terminal flag.|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module theta_slice_sequencer_slice_counter
  import theta_slice_sequencer_pkg::*;
#(
  parameter int CNT_W      = c_CNT_W,
  parameter int NUM_SLICES = c_NUM_SLICES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_terminal
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_SLICES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_terminal;

  assign w_terminal = (r_cnt == c_LAST);

  // Wrap explicitly at the last slice so the select never leaves 0..NUM_SLICES-1.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_terminal ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_terminal = w_terminal;

endmodule
`default_nettype wire

// File: rtl/theta_slice_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | theta_slice_sequencer                                             |
// | Clears the slice registers, then sweeps one write per slice.      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module theta_slice_sequencer
  import theta_slice_sequencer_pkg::*;
#(
  parameter int CNT_W      = c_CNT_W,
  parameter int NUM_SLICES = c_NUM_SLICES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic [CNT_W-1:0] cntSelOut,
  output logic             regRst,
  output logic             regWrite,
  output logic             busy,
  output logic             done
);

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [CNT_W-1:0] w_cnt;
  logic             w_terminal;
  logic             w_cntClear;
  logic             w_cntEnable;

  // Counter only moves in RUN; every other state parks it at zero.
  assign w_cntClear  = (r_state != c_RUN);
  assign w_cntEnable = (r_state == c_RUN) && !stall;

  theta_slice_sequencer_slice_counter #(
    .CNT_W      (CNT_W),
    .NUM_SLICES (NUM_SLICES)
  ) u_sliceCounter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_cntClear),
    .i_enable   (w_cntEnable),
    .o_cnt      (w_cnt),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (start) w_nextState = c_CLEAR;
      c_CLEAR: w_nextState = c_RUN;
      c_RUN:   if (!stall && w_terminal) w_nextState = c_DONE;
      c_DONE:  w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    cntSelOut = w_cnt;
    regRst    = rst || (r_state == c_CLEAR);
    regWrite  = (r_state == c_RUN) && !stall && !rst;
    busy      = (r_state != c_IDLE);
    done      = (r_state == c_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_theta_slice_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_theta_slice_sequencer                                          |
// | Self-checking bench: sweep-position model plus directed timing.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_theta_slice_sequencer;

  localparam int NS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic       stall = 1'b0;
  logic [5:0] cntSelOut;
  logic       regRst, regWrite, busy, done;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  theta_slice_sequencer #(.CNT_W(6), .NUM_SLICES(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .cntSelOut (cntSelOut),
    .regRst    (regRst),
    .regWrite  (regWrite),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Sweep position: -1 idle, 0 clear, 1..NS writing slice pos-1, NS+1 done.
  int pos = -1;
  bit modelValid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      pos <= -1;
      modelValid <= 1'b1;
    end else if (pos == -1) pos <= start ? 0 : -1;
    else if (pos == 0)      pos <= 1;
    else if (pos <= NS)     pos <= stall ? pos : pos + 1;
    else                    pos <= -1;
  end

  int nextWrite = 0;
  always @(negedge clk) begin
    bit inRun;
    if (modelValid) begin
      inRun = (pos >= 1) && (pos <= NS);
      chk("cntSelOut", cntSelOut, inRun ? pos - 1 : 0);
      chk("regRst",    regRst,    rst || (pos == 0));
      chk("regWrite",  regWrite,  inRun && !stall && !rst);
      chk("busy",      busy,      pos != -1);
      chk("done",      done,      pos == NS + 1);
      if (rst) nextWrite = 0;
      else begin
        if (regWrite) begin
          chk("writeOrder", cntSelOut, nextWrite);
          nextWrite++;
        end
        if (done) begin
          chk("writesPerSweep", nextWrite, NS);
          nextWrite = 0;
        end
      end
    end
  end

  // Per-cycle snapshots for directed tests, indexed by cycle after the start edge.
  int   doneAt[$];
  int   writesSeen;
  logic rrAt[0:255];
  logic busyAt[0:255];
  logic wrAt[0:255];
  logic [5:0] selAt[0:255];

  task automatic runSeq(input int len, input int startFrom, input int startTo,
                        input int stallFrom, input int stallLen, input int rstAt);
    doneAt.delete();
    writesSeen = 0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; stall = 1'b0;
    for (int r = 1; r <= len; r++) begin
      @(posedge clk); #1;
      start = (r >= startFrom) && (r <= startTo);
      stall = (r >= stallFrom) && (r < stallFrom + stallLen);
      rst   = (r == rstAt);
      @(negedge clk);
      if (r < 256) begin
        rrAt[r] = regRst; busyAt[r] = busy; wrAt[r] = regWrite; selAt[r] = cntSelOut;
      end
      if (done) doneAt.push_back(r);
      if (regWrite) writesSeen++;
    end
    start = 1'b0; stall = 1'b0; rst = 1'b0;
  endtask

  task automatic settle();
    int k;
    k = 0;
    @(posedge clk); #1;
    start = 1'b0; stall = 1'b0; rst = 1'b0;
    while (busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("settleIdle", busy, 0);
  endtask

  function automatic int firstDone();
    return (doneAt.size() > 0) ? doneAt[0] : -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with start high
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rstRegRst", regRst, 1);
      chk("rstBusy", busy, 0);
      chk("rstSel", cntSelOut, 0);
      chk("rstWrite", regWrite, 0);
      chk("rstDone", done, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("postRstRegRst", regRst, 0);

    // Nominal sweep
    runSeq(70, 1, 0, 0, 0, 0);
    chk("nomDoneCycle", firstDone(), 66);
    chk("nomDoneCount", doneAt.size(), 1);
    chk("nomClear", rrAt[1], 1);
    chk("nomFirstSel", selAt[2], 0);
    chk("nomLastSel", selAt[65], 63);
    chk("nomNoWriteAtDone", wrAt[66], 0);
    chk("nomIdle67", busyAt[67], 0);
    chk("nomWrites", writesSeen, 64);
    settle();

    // Stall for 3 cycles at select 10
    runSeq(75, 1, 0, 12, 3, 0);
    chk("stall10Sel", selAt[14], 10);
    chk("stall10NoWrite", wrAt[13], 0);
    chk("stall10Done", firstDone(), 69);
    chk("stall10Writes", writesSeen, 64);
    settle();

    // Stall for 2 cycles at select 63
    runSeq(75, 1, 0, 65, 2, 0);
    chk("stall63Sel", selAt[66], 63);
    chk("stall63Done", firstDone(), 68);
    settle();

    // Start held from mid-sweep through DONE is ignored until IDLE
    runSeq(68, 30, 67, 0, 0, 0);
    chk("ignDoneCount", doneAt.size(), 1);
    chk("ignDoneCycle", firstDone(), 66);
    chk("ignIdle67", busyAt[67], 0);
    chk("ignClear68", rrAt[68], 1);
    settle();

    // Reset in the middle of a sweep
    runSeq(70, 1, 0, 0, 0, 40);
    chk("midRstSel", selAt[40], 38);
    chk("midRstRegRst", rrAt[40], 1);
    chk("midRstNoWrite", wrAt[40], 0);
    chk("midRstIdle", busyAt[41], 0);
    chk("midRstCnt", selAt[41], 0);
    chk("midRstNoDone", doneAt.size(), 0);
    settle();
    runSeq(70, 1, 0, 0, 0, 0);
    chk("afterRstWrites", writesSeen, 64);
    chk("afterRstDone", firstDone(), 66);
    settle();

    // Start held continuously: period of 67 cycles
    runSeq(205, 1, 205, 0, 0, 0);
    chk("b2bDoneCount", doneAt.size(), 3);
    if (doneAt.size() == 3) begin
      chk("b2bDone0", doneAt[0], 66);
      chk("b2bDone1", doneAt[1], 133);
      chk("b2bDone2", doneAt[2], 200);
    end
    settle();

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 599) == 0);
    end
    settle();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
